present_cipher_core: RTL

- Parametrised PRESENT block cipher engine (64-bit block) with 80- or 128-bit key, encrypt and decrypt modes, and valid/ready handshakes on both sides.
- Executes one round per clock.
- Runs a key-expansion pass on every key load so that decryption can start from the final round key.
- Sits between the bus/DMA front end and the crypto result buffer as the next-generation cipher core.

---
 rtl/present_cipher_core_if.sv | 20 ++
 rtl/present_cipher_core.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/present_cipher_core_if.sv
// rtl/present_cipher_core_if.sv - key/block/result handshake bundle for the PRESENT core
interface present_cipher_core_if #(
  parameter int KEY_WIDTH = 80
);
  logic                 key_load;
  logic [KEY_WIDTH-1:0] key_in;
  logic                 key_ready;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [63:0]          in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_data;

  modport master (output key_load, key_in, in_valid, in_mode, in_data, out_ready,
                  input  key_ready, in_ready, out_valid, out_data);
  modport slave  (input  key_load, key_in, in_valid, in_mode, in_data, out_ready,
                  output key_ready, in_ready, out_valid, out_data);
endinterface

// File: rtl/present_cipher_core.sv
// rtl/present_cipher_core.sv - PRESENT-64 encrypt/decrypt engine, one round per clock
module present_cipher_core #(
  parameter int KEY_WIDTH = 80,
  parameter int NR_ROUNDS = 31
) (
  input logic                  clk,
  input logic                  n_reset,
  present_cipher_core_if.slave bus
);
  if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
    $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
  end
  if (NR_ROUNDS < 1 || NR_ROUNDS > 31) begin : g_bad_rounds
    $error("present_cipher_core: NR_ROUNDS must be 1..31");
  end

  localparam int         XOR_LSB    = (KEY_WIDTH == 128) ? 62 : 15;
  localparam logic [4:0] LAST_ROUND = 5'(NR_ROUNDS);

  typedef enum logic [1:0] {IDLE, KEYEXP, BUSY, DONE} state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // Inverse table is searched out of the forward one so the two can never disagree.
  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    for (int v = 0; v < 16; v++) begin
      if (sbox(4'(v)) == x) r = 4'(v);
    end
    return r;
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] s_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox_inv(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[(j == 63) ? 63 : (16 * j) % 63] = x[j];
    return y;
  endfunction

  function automatic logic [63:0] p_inv_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[j] = x[(j == 63) ? 63 : (16 * j) % 63];
    return y;
  endfunction

  function automatic logic [KEY_WIDTH-1:0] key_f(input logic [KEY_WIDTH-1:0] k, input logic [4:0] i);
    logic [KEY_WIDTH-1:0] t;
    t = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
    t[KEY_WIDTH-1 -: 4] = sbox(t[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) t[KEY_WIDTH-5 -: 4] = sbox(t[KEY_WIDTH-5 -: 4]);
    t[XOR_LSB +: 5] = t[XOR_LSB +: 5] ^ i;
    return t;
  endfunction

  function automatic logic [KEY_WIDTH-1:0] key_f_inv(input logic [KEY_WIDTH-1:0] k, input logic [4:0] i);
    logic [KEY_WIDTH-1:0] t;
    t = k;
    t[XOR_LSB +: 5] = t[XOR_LSB +: 5] ^ i;
    t[KEY_WIDTH-1 -: 4] = sbox_inv(t[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) t[KEY_WIDTH-5 -: 4] = sbox_inv(t[KEY_WIDTH-5 -: 4]);
    return {t[60:0], t[KEY_WIDTH-1:61]};
  endfunction

  state_t               state, state_nx;
  logic [KEY_WIDTH-1:0] ekey, dkey, kreg, key_fwd, key_bwd, key_nx;
  logic [63:0]          st, st_nx, out_data_q;
  logic [4:0]           rnd;
  logic                 mode, kx_fin, key_ready_q, can_accept, last_round;

  // kreg is the expansion scratch register during KEYEXP and the live round key during BUSY.
  assign key_fwd    = key_f(kreg, rnd);
  assign key_bwd    = key_f_inv(kreg, rnd);
  assign key_nx     = mode ? key_bwd : key_fwd;
  assign st_nx      = mode ? s_inv_layer(p_inv_layer(st ^ kreg[KEY_WIDTH-1 -: 64]))
                           : p_layer(s_layer(st ^ kreg[KEY_WIDTH-1 -: 64]));
  assign last_round = mode ? (rnd == 5'd1) : (rnd == LAST_ROUND);
  assign can_accept = (state == IDLE) && key_ready_q && !bus.key_load;

  assign bus.key_ready = key_ready_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = can_accept;
    bus.out_valid = (state == DONE);
    case (state)
      IDLE:    if (bus.key_load) state_nx = KEYEXP;
               else if (bus.in_valid && can_accept) state_nx = BUSY;
      KEYEXP:  if (!bus.key_load && kx_fin) state_nx = IDLE;
      BUSY:    if (last_round) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ekey        <= '0;
      dkey        <= '0;
      kreg        <= '0;
      st          <= '0;
      out_data_q  <= '0;
      rnd         <= '0;
      mode        <= 1'b0;
      kx_fin      <= 1'b0;
      key_ready_q <= 1'b0;
    end else if (bus.key_load && (state == IDLE || state == KEYEXP)) begin
      ekey        <= bus.key_in;
      kreg        <= bus.key_in;
      rnd         <= 5'd1;
      kx_fin      <= 1'b0;
      key_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && can_accept) begin
          st   <= bus.in_data;
          mode <= bus.in_mode;
          kreg <= bus.in_mode ? dkey : ekey;
          rnd  <= bus.in_mode ? LAST_ROUND : 5'd1;
        end
        KEYEXP: if (kx_fin) begin
          dkey        <= kreg;
          key_ready_q <= 1'b1;
          kx_fin      <= 1'b0;
        end else begin
          kreg <= key_fwd;
          // Hold the counter at the last round so it never leaves 1..31.
          if (rnd == LAST_ROUND) kx_fin <= 1'b1;
          else                   rnd    <= rnd + 5'd1;
        end
        BUSY: begin
          st   <= st_nx;
          kreg <= key_nx;
          if (last_round)  out_data_q <= st_nx ^ key_nx[KEY_WIDTH-1 -: 64];
          else if (mode)   rnd        <= rnd - 5'd1;
          else             rnd        <= rnd + 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
